// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Brief    : Shared constants and types for the PS/2 keyboard receive path.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  localparam logic [7:0] KBD_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

endpackage
`default_nettype wire

// File: rtl/kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_event_fifo
// Brief    : Key-event buffer; head entry is always presented, drops on full.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [9:0] i_data,
  input  logic       i_pop_req,
  output logic [9:0] o_head,
  output logic       o_valid,
  output logic       o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  kbd_event_t  r_mem [FIFO_DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot first, so a push into a full buffer that is being
  // drained in the same cycle still lands.
  assign w_pop      = i_pop_req & ~w_empty;
  assign w_wr       = i_push & (~w_full | w_pop);
  assign o_overflow = i_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage is reset so the head reads as zero before the first event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= kbd_event_t'(i_data);
    end
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid = ~w_empty;

endmodule
`default_nettype wire

// File: rtl/kbd_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kbd_frame_sequencer
// Brief    : PS/2 receive path: sync, frame, validate, fold E0/F0, buffer.
//            Parity checking is built only when KBD_PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_frame_sequencer
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int              WDW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]  c_timeout = WDW'(TIMEOUT_CYCLES);

  logic r_clk_s1, r_clk_s2, r_clk_hist;
  logic r_data_s1, r_data_s2;
  logic w_fall;

  frame_state_t   r_state;
  frame_state_t   w_state_nxt;
  logic [3:0]     r_bit_cnt;
  logic [10:0]    r_shift;
  logic [WDW-1:0] r_wdog;
  logic           w_timeout;

  logic       w_parity_ok;
  logic       w_frame_ok;
  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_is_ext;
  logic       w_is_brk;
  logic       w_push;
  logic       r_ext_f;
  logic       r_brk_f;
  kbd_event_t w_event;
  logic [9:0] w_head;
  kbd_event_t w_head_evt;

  // Synchronizers and history idle high, matching an undriven PS/2 line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_data_s1  <= ps2_data;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall    = r_clk_hist & ~r_clk_s2;
  assign w_timeout = (r_state == SHIFT) && (r_wdog == c_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
        end else if (w_fall && (r_bit_cnt == 4'd10)) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_byte_valid = 1'b0;
    frame_err    = 1'b0;
    case (r_state)
      CHECK: begin
        w_byte_valid = w_frame_ok;
        frame_err    = ~w_frame_ok;
      end
      SHIFT:   frame_err = w_timeout;
      default: ;
    endcase
  end

  // Bits enter at the top so that after 11 shifts bit 0 (start) sits at [0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_fall) begin
            r_shift   <= {r_data_s2, r_shift[10:1]};
            r_bit_cnt <= 4'd1;
          end
        end
        SHIFT: begin
          if (w_timeout) begin
            r_bit_cnt <= '0;
            r_wdog    <= '0;
          end else if (w_fall) begin
            r_shift   <= {r_data_s2, r_shift[10:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_wdog    <= '0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_wdog    <= '0;
        end
      endcase
    end
  end

`ifdef KBD_PARITY_CHECK_EN
  assign w_parity_ok = ^r_shift[9:1];
`else
  logic w_unused_parity;
  assign w_unused_parity = r_shift[9];
  assign w_parity_ok     = 1'b1;
`endif

  assign w_frame_ok = ~r_shift[0] & r_shift[10] & w_parity_ok;
  assign w_byte     = r_shift[8:1];
  assign w_is_ext   = (w_byte == KBD_PREFIX_EXT);
  assign w_is_brk   = (w_byte == KBD_PREFIX_BRK);
  assign w_push     = w_byte_valid & ~w_is_ext & ~w_is_brk;
  assign w_event    = '{ext: r_ext_f, brk: r_brk_f, code: w_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_f <= 1'b0;
      r_brk_f <= 1'b0;
    end else if (frame_err) begin
      r_ext_f <= 1'b0;
      r_brk_f <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_is_ext) begin
        r_ext_f <= 1'b1;
      end else if (w_is_brk) begin
        r_brk_f <= 1'b1;
      end else begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end
    end
  end

  kbd_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_push),
    .i_data     (w_event),
    .i_pop_req  (key_ready),
    .o_head     (w_head),
    .o_valid    (key_valid),
    .o_overflow (overflow)
  );

  assign w_head_evt = kbd_event_t'(w_head);
  assign key_code   = w_head_evt.code;
  assign key_ext    = w_head_evt.ext;
  assign key_break  = w_head_evt.brk;

endmodule
`default_nettype wire

// File: tb/tb_kbd_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_frame_sequencer
// Brief    : Scoreboard bench for kbd_frame_sequencer driving bit-level frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_frame_sequencer;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int exp_err = 0;
  int exp_ovf = 0;

  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  always #5 clk = ~clk;

  kbd_frame_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame bits LSB-first: start, 8 data, odd parity (optionally corrupted), stop.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_code", key_code, 8'h00);
    chk("rst_ext", key_ext, 1'b0);
    chk("rst_brk", key_break, 1'b0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          chk("evt_spurious", {22'd0, key_ext, key_break, key_code}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_code", key_code, mon_e[7:0]);
          chk("evt_ext", key_ext, mon_e[9]);
          chk("evt_brk", key_break, mon_e[8]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Plain make code
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 11);
    wait_drain();
    chk("t1_ferr", err_cnt, exp_err);

    // Extended break folds into one event
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    wait_drain();

    // Corrupted parity
`ifdef KBD_PARITY_CHECK_EN
    exp_err++;
`else
    exp_q.push_back({2'b00, 8'h1C});
`endif
    send_frame(8'h1C, 1'b1, 11);
    wait_drain();
    chk("t3_ferr", err_cnt, exp_err);

    // Stalled frame then a clean one
    exp_err++;
    send_frame(8'h33, 1'b0, 5);
    repeat (TIMEOUT + 10) @(posedge clk);
    chk("t4_timeout_ferr", err_cnt, exp_err);
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0, 11);
    wait_drain();
    chk("t4_ferr", err_cnt, exp_err);

    // Backpressure and overflow
    @(posedge clk);
    #1 key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back({2'b00, 8'(k)});
      send_frame(8'(k), 1'b0, 11);
    end
    exp_ovf++;
    chk("t5_ovf", ovf_cnt, exp_ovf);
    @(negedge clk);
    chk("t5_head_valid", key_valid, 1'b1);
    chk("t5_head_code", key_code, 8'h01);
    @(posedge clk);
    #1 key_ready = 1'b1;
    wait_drain();
    chk("t5_ovf_after", ovf_cnt, exp_ovf);

    // Reset mid-frame also discards a pending E0 prefix
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 6);
    @(posedge clk);
    #1 reset = 1'b1;
    chk_reset_outputs();
    chk_reset_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 11);
    wait_drain();

    @(negedge clk);
    chk("end_valid", key_valid, 1'b0);
    chk("end_ferr", err_cnt, exp_err);
    chk("end_ovf", ovf_cnt, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
